// File: rtl/ct_f_spsram_4096x128_ctrl.sv
// ct_f_spsram_4096x128_ctrl: request front-end for a global-write-enable SRAM, turning masked writes into read-merge-write
module ct_f_spsram_4096x128_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 128,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_bmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rmw_busy,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);
  localparam int PW = $clog2(RSP_DEPTH);
  typedef enum logic [1:0] {IDLE, RMW_MRG, RMW_WR} state_t;
  state_t state, state_nxt;
  logic rd_inflight, acc, full_m, zero_m, push, pop;
  logic [ADDR_WIDTH-1:0] rmw_a;
  logic [DATA_WIDTH-1:0] rmw_d, rmw_m;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] fifo_cnt;
  assign full_m    = &req_bmask;
  assign zero_m    = ~|req_bmask;
  assign req_rdy   = cpurst_b && state == IDLE &&
                     (req_wr || (fifo_cnt + (PW+1)'(rd_inflight)) < (PW+1)'(RSP_DEPTH));
  assign acc       = req_vld && req_rdy;
  assign push      = rd_inflight;
  assign pop       = rsp_vld && rsp_rdy;
  assign rsp_vld   = fifo_cnt != '0;
  assign rsp_rdata = fifo_mem[rd_ptr];
  assign rmw_busy  = state != IDLE;
  // SRAM pin drive and next state: direct access in IDLE, merged write-back in RMW_WR
  always_comb begin
    state_nxt = state;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (state == RMW_WR) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = rmw_a;
      sram_d    = rmw_d;
      state_nxt = IDLE;
    end else if (state == RMW_MRG) begin
      state_nxt = RMW_WR;
    end else if (acc && !(req_wr && zero_m)) begin
      sram_cen = 1'b0;
      sram_a   = req_addr;
      if (req_wr && full_m) begin
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_d    = req_wdata;
      end else if (req_wr) begin
        state_nxt = RMW_MRG;
      end
    end
  end
  // Control state; rmw_d holds write data until RMW_MRG overwrites it with the merged word
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state       <= IDLE;
      rd_inflight <= 1'b0;
      rmw_a       <= '0;
      rmw_d       <= '0;
      rmw_m       <= '0;
    end else begin
      state       <= state_nxt;
      rd_inflight <= acc && !req_wr;
      if (acc) begin
        rmw_a <= req_addr;
        rmw_d <= req_wdata;
        rmw_m <= req_bmask;
      end
      if (state == RMW_MRG) rmw_d <= (sram_q & ~rmw_m) | (rmw_d & rmw_m);
    end
  end
  // Response FIFO bookkeeping; capacity is reserved at issue so a push never meets a full FIFO
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // Response storage captures SRAM read data the cycle after a user read
  always_ff @(posedge forever_cpuclk) begin
    if (push) fifo_mem[wr_ptr] <= sram_q;
  end
endmodule
